// File: rtl/dreq_split.sv
// dreq_split: breaks one arbitrated data request into chunk requests that
// never exceed MAX_CHUNK bytes and never cross a 2^PAGE_BITS-byte boundary.
// The tag is copied to every chunk; `last` is only raised on the final chunk
// of a request that arrived with `last` set.
module dreq_split #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28,
  parameter int TAG_BITS   = 8,
  parameter int PAGE_BITS  = 12,
  parameter int MAX_CHUNK  = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [VADDR_BITS-1:0] s_req_vaddr,
  input  logic [LEN_BITS-1:0]   s_req_len,
  input  logic                  s_req_last,
  input  logic [TAG_BITS-1:0]   s_req_tag,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [VADDR_BITS-1:0] m_req_vaddr,
  output logic [LEN_BITS-1:0]   m_req_len,
  output logic                  m_req_last,
  output logic [TAG_BITS-1:0]   m_req_tag,
  output logic [15:0]           m_req_idx
);

  // One extra bit so a full page of room (2^PAGE_BITS) is representable
  // even when PAGE_BITS == LEN_BITS.
  localparam int LW = LEN_BITS + 1;
  localparam logic [LW-1:0] PAGE_SIZE = LW'(1) << PAGE_BITS;
  localparam logic [LW-1:0] MAX_LW    = LW'(MAX_CHUNK);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [VADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_BITS-1:0]   rem_len_q, rem_len_d;
  logic [15:0]           idx_q, idx_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  last_q, last_d;

  logic [LEN_BITS-1:0]   chunk;
  logic                  chunk_final;

  // min(remaining, MAX_CHUNK, room to the next page boundary); the result
  // never exceeds `rem`, so dropping the guard bit loses nothing.
  function automatic logic [LEN_BITS-1:0] chunk_len(
    input logic [LEN_BITS-1:0]  rem,
    input logic [PAGE_BITS-1:0] page_off
  );
    logic [LW-1:0] room;
    logic [LW-1:0] c;
    room = PAGE_SIZE - LW'(page_off);
    c    = {1'b0, rem};
    if (MAX_LW < c) c = MAX_LW;
    if (room < c)   c = room;
    return c[LEN_BITS-1:0];
  endfunction

  // Chunk sizing from registered state only, so outputs have no path from inputs.
  always_comb begin
    chunk       = chunk_len(rem_len_q, cur_addr_q[PAGE_BITS-1:0]);
    chunk_final = (chunk == rem_len_q);
  end

  assign s_req_ready = (state_q == IDLE) && aresetn;
  assign m_req_valid = (state_q == SPLIT);
  assign m_req_vaddr = cur_addr_q;
  assign m_req_len   = chunk;
  assign m_req_last  = last_q && chunk_final;
  assign m_req_tag   = tag_q;
  assign m_req_idx   = idx_q;

  // Next-state: latch a request in IDLE, advance one chunk per handshake in SPLIT.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        if (s_req_valid) begin
          cur_addr_d = s_req_vaddr;
          rem_len_d  = s_req_len;
          last_d     = s_req_last;
          tag_d      = s_req_tag;
          idx_d      = '0;
          state_d    = SPLIT;
        end
      end
      SPLIT: begin
        if (m_req_ready) begin
          if (chunk_final) begin
            state_d = IDLE;
          end else begin
            cur_addr_d = cur_addr_q + VADDR_BITS'(chunk);
            rem_len_d  = rem_len_q - chunk;
            idx_d      = idx_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers; reset abandons any request in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
    end
  end

endmodule
